// File: rtl/lights_pkg.sv
// Shared definitions for the LED colour sequencer and its receive-side monitor.
package lights_pkg;

    localparam logic [2:0] COL_MIN = 3'b001;
    localparam logic [2:0] COL_MAX = 3'b110;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_ILLEGAL = 2'b01,
        ERR_SKIP    = 2'b10,
        ERR_NOSYNC  = 2'b11
    } err_code_e;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_e;

    // Next colour in the cyclic sequence 1..6
    function automatic logic [2:0] succ(input logic [2:0] c);
        return (c == COL_MAX) ? COL_MIN : 3'(c + 3'd1);
    endfunction

    function automatic logic is_legal(input logic [2:0] c);
        return (c >= COL_MIN) && (c <= COL_MAX);
    endfunction

endpackage

// File: rtl/lights_monitor_if.sv
// Colour stream plus decoded status between the LED sequencer side and the monitor.
interface lights_monitor_if #(
    parameter int unsigned COUNT_W = 16,
    parameter int unsigned LAP_W   = 8
);
    logic [2:0]         colour;
    logic               step;
    logic               lap;
    logic               idle;
    logic [COUNT_W-1:0] step_count;
    logic [LAP_W-1:0]   lap_count;
    logic               err;
    logic [1:0]         err_code;
    logic               sync;

    modport master (
        output colour,
        input  step, lap, idle, step_count, lap_count, err, err_code, sync
    );

    modport slave (
        input  colour,
        output step, lap, idle, step_count, lap_count, err, err_code, sync
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that holds at MAX; synchronous reset and clear.
module sat_counter #(
    parameter int unsigned   W   = 8,
    parameter logic [W-1:0]  MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/lights_monitor.sv
// Receive-side checker for the 3-bit LED colour stream: decodes steps, laps and idle,
// and flags illegal codes, skipped steps and unsynchronised codes.
module lights_monitor
    import lights_pkg::*;
#(
    parameter int unsigned COUNT_W     = 16,
    parameter int unsigned LAP_W       = 8,
    parameter int unsigned IDLE_CYCLES = 8,
    parameter bit          STICKY      = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    lights_monitor_if.slave  bus
);

    localparam int unsigned HOLD_W = 8;

    state_e      state, state_nxt;
    logic [2:0]  prev, prev_nxt;
    err_code_e   code_q, code_nxt;
    logic        step_q, lap_q, idle_q, err_q, sync_q;
    logic        step_nxt, lap_nxt, idle_nxt;
    logic        hold_inc, hold_clr;
    logic [HOLD_W-1:0] hold_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= SYNC;
            prev   <= COL_MIN;
            code_q <= ERR_NONE;
            step_q <= 1'b0;
            lap_q  <= 1'b0;
            idle_q <= 1'b0;
            err_q  <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            prev   <= prev_nxt;
            code_q <= code_nxt;
            step_q <= step_nxt;
            lap_q  <= lap_nxt;
            idle_q <= idle_nxt;
            err_q  <= (state_nxt == FAULT);
            sync_q <= (state_nxt == TRACK);
        end
    end

    always_comb begin
        state_nxt = state;
        prev_nxt  = prev;
        code_nxt  = code_q;
        step_nxt  = 1'b0;
        lap_nxt   = 1'b0;
        hold_inc  = 1'b0;
        hold_clr  = 1'b1;
        case (state)
            SYNC: begin
                if (bus.colour == COL_MIN) begin
                    state_nxt = TRACK;
                    prev_nxt  = COL_MIN;
                end else if (!is_legal(bus.colour)) begin
                    state_nxt = FAULT;
                    code_nxt  = ERR_ILLEGAL;
                end else begin
                    code_nxt  = ERR_NOSYNC;
                end
            end
            TRACK: begin
                if (bus.colour == prev) begin
                    hold_inc = 1'b1;
                    hold_clr = 1'b0;
                end else if (bus.colour == succ(prev)) begin
                    step_nxt = 1'b1;
                    lap_nxt  = (prev == COL_MAX);
                    prev_nxt = bus.colour;
                end else if (!is_legal(bus.colour)) begin
                    state_nxt = FAULT;
                    code_nxt  = ERR_ILLEGAL;
                end else begin
                    state_nxt = FAULT;
                    code_nxt  = ERR_SKIP;
                end
            end
            FAULT: begin
                if (!STICKY) begin
                    state_nxt = SYNC;
                end
            end
            default: begin
                state_nxt = SYNC;
            end
        endcase
        // hold_cnt is the pre-update value, so idle follows the counter by one edge
        idle_nxt = hold_inc && (hold_cnt == HOLD_W'(IDLE_CYCLES));
    end

    sat_counter #(.W(COUNT_W)) u_step_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (step_nxt),
        .count (bus.step_count)
    );

    sat_counter #(.W(LAP_W)) u_lap_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (lap_nxt),
        .count (bus.lap_count)
    );

    sat_counter #(.W(HOLD_W), .MAX(HOLD_W'(IDLE_CYCLES))) u_hold_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (hold_clr),
        .inc   (hold_inc),
        .count (hold_cnt)
    );

    assign bus.step     = step_q;
    assign bus.lap      = lap_q;
    assign bus.idle     = idle_q;
    assign bus.err      = err_q;
    assign bus.err_code = code_q;
    assign bus.sync     = sync_q;

endmodule

// File: tb/tb_lights_monitor.sv
// Directed bench for lights_monitor: sticky default instance, a non-sticky one and a narrow-counter one.
module tb_lights_monitor;
    import lights_pkg::*;

    typedef struct packed {
        logic        step;
        logic        lap;
        logic        idle;
        logic        err;
        logic [1:0]  code;
        logic        sync;
        logic [15:0] sc;
        logic [7:0]  lc;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] colour = 3'b001;
    int         checks = 0;
    int         errors = 0;
    obs_t       sb_q[$];

    always #5 clk = ~clk;

    lights_monitor_if #(.COUNT_W(16), .LAP_W(8)) ifa ();
    lights_monitor_if #(.COUNT_W(16), .LAP_W(8)) ifb ();
    lights_monitor_if #(.COUNT_W(4),  .LAP_W(8)) ifc ();

    assign ifa.colour = colour;
    assign ifb.colour = colour;
    assign ifc.colour = colour;

    lights_monitor #(.COUNT_W(16), .LAP_W(8), .IDLE_CYCLES(8), .STICKY(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa));
    lights_monitor #(.COUNT_W(16), .LAP_W(8), .IDLE_CYCLES(8), .STICKY(1'b0)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb));
    lights_monitor #(.COUNT_W(4),  .LAP_W(8), .IDLE_CYCLES(8), .STICKY(1'b1)) dut_c (
        .clk(clk), .rst(rst), .bus(ifc));

    function automatic obs_t mk(input logic st, input logic lp, input logic id, input logic er,
                                input logic [1:0] cd, input logic sy, input int sc, input int lc);
        return '{st, lp, id, er, cd, sy, 16'(sc), 8'(lc)};
    endfunction

    function automatic obs_t sample_a();
        return '{ifa.step, ifa.lap, ifa.idle, ifa.err, ifa.err_code, ifa.sync,
                 ifa.step_count, ifa.lap_count};
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("step=%0b lap=%0b idle=%0b err=%0b code=%0d sync=%0b step_count=%0d lap_count=%0d",
                         o.step, o.lap, o.idle, o.err, o.code, o.sync, o.sc, o.lc);
    endfunction

    // Drive one sample on the main instance, expect the registered response after the edge
    task automatic cyc(input logic [2:0] c, input obs_t e, input string tag);
        obs_t exp_v;
        obs_t got;
        colour = c;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        exp_v = sb_q.pop_front();
        got   = sample_a();
        checks++;
        assert (got === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %s expected %s", tag, fmt(got), fmt(exp_v));
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp_v);
        checks++;
        assert (got === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp_v);
        end
    endtask

    initial begin
        // Reset, then hold 001: track immediately, idle after the hold counter reaches 8
        rst = 1'b1;
        cyc(3'd1, mk(0, 0, 0, 0, 2'd0, 0, 0, 0), "reset");
        rst = 1'b0;
        chk("b_reset_err", 16'(ifb.err), 16'd0);
        chk("c_reset_count", 16'(ifc.step_count), 16'd0);
        for (int i = 1; i <= 10; i++)
            cyc(3'd1, mk(0, 0, logic'(i == 10), 0, 2'd0, 1, 0, 0), $sformatf("hold%0d", i));

        // Full lap 2..6,1,2
        for (int i = 0; i < 7; i++)
            cyc(3'((i + 1) % 6 + 1), mk(1, logic'(i == 5), 0, 0, 2'd0, 1, i + 1, (i >= 5) ? 1 : 0),
                $sformatf("seq%0d", i));

        // Skip 3 -> 5: sticky fault freezes counts; non-sticky instance resyncs
        rst = 1'b1;
        cyc(3'd1, mk(0, 0, 0, 0, 2'd0, 0, 0, 0), "rst2");
        rst = 1'b0;
        cyc(3'd1, mk(0, 0, 0, 0, 2'd0, 1, 0, 0), "sync2");
        cyc(3'd2, mk(1, 0, 0, 0, 2'd0, 1, 1, 0), "s2");
        cyc(3'd3, mk(1, 0, 0, 0, 2'd0, 1, 2, 0), "s3");
        cyc(3'd5, mk(0, 0, 0, 1, 2'b10, 0, 2, 0), "skip");
        chk("b_skip_err", 16'(ifb.err), 16'd1);
        chk("b_skip_code", 16'(ifb.err_code), 16'd2);
        for (int i = 1; i <= 20; i++) begin
            cyc(3'd1, mk(0, 0, 0, 1, 2'b10, 0, 2, 0), $sformatf("sticky%0d", i));
            if (i == 1) begin
                chk("b_after_fault_err", 16'(ifb.err), 16'd0);
                chk("b_after_fault_sync", 16'(ifb.sync), 16'd0);
                chk("b_code_retained", 16'(ifb.err_code), 16'd2);
            end
            if (i == 2)
                chk("b_resync", 16'(ifb.sync), 16'd1);
        end

        // Illegal 111 in TRACK
        rst = 1'b1;
        cyc(3'd1, mk(0, 0, 0, 0, 2'd0, 0, 0, 0), "rst3");
        rst = 1'b0;
        cyc(3'd1, mk(0, 0, 0, 0, 2'd0, 1, 0, 0), "sync3");
        cyc(3'd7, mk(0, 0, 0, 1, 2'b01, 0, 0, 0), "ill111");
        chk("b_ill111_err", 16'(ifb.err), 16'd1);
        chk("b_ill111_code", 16'(ifb.err_code), 16'd1);
        cyc(3'd1, mk(0, 0, 0, 1, 2'b01, 0, 0, 0), "ill111_hold");
        chk("b_ill111_sync_state", 16'({ifb.err, ifb.sync, ifb.err_code}), 16'b0001);
        cyc(3'd1, mk(0, 0, 0, 1, 2'b01, 0, 0, 0), "ill111_hold2");
        chk("b_ill111_resync", 16'(ifb.sync), 16'd1);

        // Illegal 000 in TRACK
        rst = 1'b1;
        cyc(3'd1, mk(0, 0, 0, 0, 2'd0, 0, 0, 0), "rst4");
        rst = 1'b0;
        cyc(3'd1, mk(0, 0, 0, 0, 2'd0, 1, 0, 0), "sync4");
        cyc(3'd0, mk(0, 0, 0, 1, 2'b01, 0, 0, 0), "ill000");
        chk("b_ill000_code", 16'(ifb.err_code), 16'd1);

        // Unsynced legal code in SYNC is informational, then an illegal code faults
        rst = 1'b1;
        cyc(3'd1, mk(0, 0, 0, 0, 2'd0, 0, 0, 0), "rst5");
        rst = 1'b0;
        cyc(3'd3, mk(0, 0, 0, 0, 2'b11, 0, 0, 0), "nosync");
        cyc(3'd0, mk(0, 0, 0, 1, 2'b01, 0, 0, 0), "sync_ill000");

        // Reset mid-stream at colour 4 with counts 3/0
        rst = 1'b1;
        cyc(3'd1, mk(0, 0, 0, 0, 2'd0, 0, 0, 0), "rst6");
        rst = 1'b0;
        cyc(3'd1, mk(0, 0, 0, 0, 2'd0, 1, 0, 0), "sync6");
        cyc(3'd2, mk(1, 0, 0, 0, 2'd0, 1, 1, 0), "m2");
        cyc(3'd3, mk(1, 0, 0, 0, 2'd0, 1, 2, 0), "m3");
        cyc(3'd4, mk(1, 0, 0, 0, 2'd0, 1, 3, 0), "m4");
        rst = 1'b1;
        cyc(3'd4, mk(0, 0, 0, 0, 2'd0, 0, 0, 0), "mid_rst");
        rst = 1'b0;
        cyc(3'd1, mk(0, 0, 0, 0, 2'd0, 1, 0, 0), "post_rst_sync");
        cyc(3'd2, mk(1, 0, 0, 0, 2'd0, 1, 1, 0), "post_rst_step");

        // 20 steps: narrow counter saturates at 15 while step keeps pulsing
        rst = 1'b1;
        cyc(3'd1, mk(0, 0, 0, 0, 2'd0, 0, 0, 0), "rst7");
        rst = 1'b0;
        cyc(3'd1, mk(0, 0, 0, 0, 2'd0, 1, 0, 0), "sync7");
        for (int n = 1; n <= 20; n++) begin
            cyc(3'(n % 6 + 1), mk(1, logic'(n % 6 == 0), 0, 0, 2'd0, 1, n, n / 6),
                $sformatf("long%0d", n));
            chk($sformatf("c_step%0d", n), 16'(ifc.step), 16'd1);
            chk($sformatf("c_count%0d", n), 16'(ifc.step_count), 16'((n > 15) ? 15 : n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

endmodule
